spi_ram: RTL and testbench
==========================

SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 8-bit memory words.
REQ-002 Parameter ADDR_SIZE, default 8, address width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 din  input  10  command word from SPI slave; din[9:8] opcode, din[7:0] payload.
REQ-006 rx_valid  input  1  din valid this cycle; one command accepted per high cycle.
REQ-007 dout  output  8  read data to SPI slave.
REQ-008 tx_valid  output  1  dout holds valid read data.
REQ-009 cmd_err  output  1  one-cycle pulse flagging an illegal command.
REQ-010 err_cnt  output  8  saturating count of illegal commands.

Function
REQ-011 Opcodes SHALL be: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-012 Sequencing FSM SHALL have states IDLE, WR_ARMED, RD_ARMED; state changes only on a cycle with rx_valid=1.
REQ-013 IDLE: 00 -> wr_addr<=din[7:0], go WR_ARMED; 10 -> rd_addr<=din[7:0], go RD_ARMED; 01/11 illegal, stay IDLE.
REQ-014 WR_ARMED: 00 reload wr_addr, stay; 01 -> mem[wr_addr]<=din[7:0], stay; 10 load rd_addr, go RD_ARMED; 11 illegal, stay.
REQ-015 RD_ARMED: 10 reload rd_addr, stay; 11 -> dout<=mem[rd_addr], go IDLE; 00 load wr_addr, go WR_ARMED; 01 illegal, stay.
REQ-016 Write latency: memory updated at the edge sampling rx_valid=1 with opcode 01.
REQ-017 Read latency: dout and tx_valid=1 SHALL appear at the edge sampling the legal 11 command (visible next cycle).
REQ-018 tx_valid SHALL stay high with dout held until the next accepted rx_valid, then clear at that edge, unless that command is itself a legal 11 (tx_valid stays 1, dout updates).
REQ-019 Illegal command: no memory write, no address change, no dout/tx_valid change; cmd_err=1 for exactly the following cycle.
REQ-020 err_cnt SHALL increment by 1 per illegal command and saturate at 255.
REQ-021 rx_valid=0: no state, address, memory or output change; cmd_err=0.
REQ-022 Back-to-back rx_valid on consecutive cycles SHALL each be processed with no stall.
REQ-023 Read of a never-written location returns unspecified data; not an error.

Reset
REQ-024 On rst_n=0, immediately and independent of clk: FSM=IDLE, wr_addr=0, rd_addr=0, dout=0, tx_valid=0, cmd_err=0, err_cnt=0.
REQ-025 Memory contents SHALL NOT be reset.
REQ-026 Reset asserted mid-sequence abandons it; any command arriving with rst_n=0 is ignored.
REQ-027 First rx_valid after rst_n deasserts SHALL be processed from IDLE.

Configuration
REQ-028 Macro RAM_AUTO_INC_EN: when defined, wr_addr SHALL increment by 1 after each legal 01 and rd_addr by 1 after each legal 11, wrapping MEM_DEPTH-1 -> 0; FSM transitions unchanged.
REQ-029 Without RAM_AUTO_INC_EN, addresses change only on 00/10 commands.

Verification
REQ-030 Reset, then 00_0x12, 01_0xA5, 10_0x12, 11_xx -> tx_valid=1, dout=0xA5 one cycle after the 11 command.
REQ-031 After reset, 01_0x33 -> cmd_err pulse 1 cycle, err_cnt=1, mem unchanged, FSM IDLE; 11_xx next -> err_cnt=2.
REQ-032 READ sequence leaving tx_valid=1, then 00_0x40 -> tx_valid=0 and dout held at same edge.
REQ-033 256 illegal commands -> err_cnt=255, no further change.
REQ-034 RAM_AUTO_INC_EN: 00_0xFF, 01_0x11, 01_0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22; read back 10_0xFF, 11, 10_0x00, 11 -> 0x11 then 0x22; without macro mem[0xFF]=0x22.
REQ-035 rst_n pulsed low between 10_0x05 and 11_xx -> 11 treated as illegal, cmd_err=1, tx_valid=0.

Source files
------------

// File: rtl/spi_ram.sv
// Command-driven byte RAM behind an SPI slave; optional RAM_AUTO_INC_EN bumps addresses after data ops.
// Latency: writes land and read data/tx_valid appear at the edge that samples the command.
// Backpressure: none; one command is accepted on every rx_valid cycle, back-to-back.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err,
    output logic [7:0] err_cnt
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_ARMED = 2'd1;
    localparam logic [1:0] RD_ARMED = 2'd2;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    logic [7:0]           mem [MEM_DEPTH];
    logic [1:0]           state;
    logic [1:0]           next_state;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] payload_addr;
    logic [1:0]           op;
    logic                 illegal;
    logic                 accept;
    logic                 wr_en;

    assign op           = din[9:8];
    assign payload_addr = ADDR_SIZE'(din[7:0]);

    // Data ops are only legal once the matching address has been armed.
    always_comb begin
        illegal    = 1'b0;
        next_state = state;
        case (op)
            OP_WR_ADDR: next_state = WR_ARMED;
            OP_RD_ADDR: next_state = RD_ARMED;
            OP_WR_DATA: illegal = (state != WR_ARMED);
            OP_RD_DATA: begin
                illegal    = (state != RD_ARMED);
                next_state = IDLE;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) next_state = state;
    end

    assign accept = rx_valid && !illegal;
    assign wr_en  = accept && (op == OP_WR_DATA);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= din[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= 8'h00;
            tx_valid <= 1'b0;
            cmd_err  <= 1'b0;
            err_cnt  <= 8'h00;
        end else begin
            cmd_err <= rx_valid && illegal;
            if (rx_valid && illegal && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            if (accept) begin
                state    <= next_state;
                tx_valid <= (op == OP_RD_DATA);
                case (op)
                    OP_WR_ADDR: wr_addr <= payload_addr;
                    OP_RD_ADDR: rd_addr <= payload_addr;
                    OP_WR_DATA: begin
`ifdef RAM_AUTO_INC_EN
                        wr_addr <= wr_addr + ADDR_SIZE'(1);
`else
                        wr_addr <= wr_addr;
`endif
                    end
                    default: begin
                        dout <= mem[rd_addr];
`ifdef RAM_AUTO_INC_EN
                        rd_addr <= rd_addr + ADDR_SIZE'(1);
`else
                        rd_addr <= rd_addr;
`endif
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: reset, write/read, illegal commands, saturation, auto-increment, reset abort.
module tb_spi_ram;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one command for exactly one rising edge; consecutive calls give back-to-back commands.
    task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
        @(negedge clk);
        din      = {op, pl};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        din      = 10'h000;
        rx_valid = 1'b0;
        idle(2);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt: got %h want 00", err_cnt); end
        // A write-address sent while in reset must be ignored, so the following write-data is illegal.
        cmd(2'b00, 8'h10);
        @(negedge clk);
        rst_n = 1'b1;
        cmd(2'b01, 8'h99);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL reset_ignores_cmd: cmd_err got %b want 1", cmd_err); end
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL reset_ignores_cnt: got %h want 01", err_cnt); end
    endtask

    task automatic test_write_read();
        do_reset();
        cmd(2'b00, 8'h12);
        cmd(2'b01, 8'hA5);
        cmd(2'b10, 8'h12);
        cmd(2'b11, 8'h00);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_tx_valid: got %b want 1", tx_valid); end
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL wr_rd_dout: got %h want a5", dout); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL wr_rd_cmd_err: got %b want 0", cmd_err); end
        idle(3);
        checks++; if (tx_valid !== 1'b1 || dout !== 8'hA5) begin
            errors++; $display("FAIL wr_rd_hold: tx_valid %b dout %h want 1 a5", tx_valid, dout);
        end
    endtask

    task automatic test_illegal();
        cmd(2'b00, 8'h00);
        cmd(2'b01, 8'h5C);
        do_reset();
        cmd(2'b01, 8'h33);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got %b want 1", cmd_err); end
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL illegal_cnt1: got %h want 01", err_cnt); end
        idle(1);
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL illegal_pulse_end: got %b want 0", cmd_err); end
        cmd(2'b11, 8'h00);
        checks++; if (err_cnt !== 8'h02) begin errors++; $display("FAIL illegal_cnt2: got %h want 02", err_cnt); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL illegal_no_tx: got %b want 0", tx_valid); end
        cmd(2'b10, 8'h00);
        cmd(2'b11, 8'h00);
        checks++; if (dout !== 8'h5C) begin errors++; $display("FAIL illegal_mem_kept: got %h want 5c", dout); end
    endtask

    task automatic test_tx_clear();
        cmd(2'b10, 8'h12);
        cmd(2'b11, 8'h00);
        checks++; if (tx_valid !== 1'b1 || dout !== 8'hA5) begin
            errors++; $display("FAIL txclr_read: tx_valid %b dout %h want 1 a5", tx_valid, dout);
        end
        cmd(2'b01, 8'h77);
        checks++; if (tx_valid !== 1'b1 || cmd_err !== 1'b1) begin
            errors++; $display("FAIL txclr_illegal_keeps: tx_valid %b cmd_err %b want 1 1", tx_valid, cmd_err);
        end
        cmd(2'b00, 8'h40);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL txclr_clear: got %b want 0", tx_valid); end
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL txclr_dout_held: got %h want a5", dout); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 255; i++) cmd(2'b11, 8'h00);
        checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_255: got %h want ff", err_cnt); end
        cmd(2'b11, 8'h00);
        checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %h want ff", err_cnt); end
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL sat_pulse: got %b want 1", cmd_err); end
    endtask

    task automatic test_auto_inc();
        logic [7:0] exp_ff;
        logic [7:0] exp_00;
`ifdef RAM_AUTO_INC_EN
        exp_ff = 8'h11;
        exp_00 = 8'h22;
`else
        exp_ff = 8'h22;
        exp_00 = 8'h5C;
`endif
        do_reset();
        cmd(2'b00, 8'hFF);
        cmd(2'b01, 8'h11);
        cmd(2'b01, 8'h22);
        cmd(2'b10, 8'hFF);
        cmd(2'b11, 8'h00);
        checks++; if (dout !== exp_ff) begin errors++; $display("FAIL autoinc_ff: got %h want %h", dout, exp_ff); end
        cmd(2'b10, 8'h00);
        cmd(2'b11, 8'h00);
        checks++; if (dout !== exp_00) begin errors++; $display("FAIL autoinc_00: got %h want %h", dout, exp_00); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cmd(2'b10, 8'h12);
        cmd(2'b11, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (dout !== 8'h00 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: dout %h tx_valid %b want 00 0", dout, tx_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cmd(2'b10, 8'h05);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cmd(2'b11, 8'h00);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL abort_cmd_err: got %b want 1", cmd_err); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_tx_valid: got %b want 0", tx_valid); end
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL abort_err_cnt: got %h want 01", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_illegal();
        test_tx_clear();
        test_saturate();
        test_auto_inc();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
